price_move_detector: RTL and testbench

Downstream consumer of the market data processor's `symbol`/`price`/`price_valid` stream. It keeps the last traded price per symbol in a small fully-associative table and computes the absolute price move against the stored value. When a move meets or exceeds a configured threshold, it queues an event record for the strategy/order logic. The event output uses a valid/ready handshake; the input side is push-only with no back-pressure.

---
 rtl/price_move_pkg.sv | 12 +
 rtl/price_evt_fifo.sv | 35 +++
 rtl/price_move_detector.sv | 120 ++++++++++++
 tb/tb_price_move_detector.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/price_move_pkg.sv
// price_move_pkg: shared types and widths for the price move detector
package price_move_pkg;
  localparam int CNT_W = 16;
  typedef logic [31:0] price_t;
  typedef logic [31:0] symbol_t;
  typedef struct packed {
    symbol_t symbol;
    price_t prev_price;
    price_t price;
    logic up;
  } price_evt_t;
endpackage

// File: rtl/price_evt_fifo.sv
// price_evt_fifo: show-ahead event queue; head reads as zero while empty
module price_evt_fifo
  import price_move_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  price_evt_t din,
  output price_evt_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  price_evt_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/price_move_detector.sv
// price_move_detector: per-symbol last-price CAM raising threshold move events.
// Drop counters are built only when PRICE_MOVE_STATS_EN is defined.
module price_move_detector
  import price_move_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int EVT_FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  symbol_t          symbol,
  input  price_t           price,
  input  logic             price_valid,
  input  price_t           cfg_threshold,
  input  logic             tbl_clear,
  output logic             evt_valid,
  input  logic             evt_ready,
  output symbol_t          evt_symbol,
  output price_t           evt_prev_price,
  output price_t           evt_price,
  output logic             evt_up,
  output logic             tbl_full,
  output logic [CNT_W-1:0] miss_drop_count,
  output logic [CNT_W-1:0] evt_drop_count
);
  localparam int IW = $clog2(DEPTH);
  logic [DEPTH-1:0] tbl_valid;
  symbol_t tbl_sym [DEPTH];
  price_t tbl_price [DEPTH];
  logic s1_v, s1_full;
  symbol_t s1_sym;
  price_t s1_price;
  logic [DEPTH-1:0] s1_match, fwd_match, free;
  logic [IW-1:0] s1_free_idx, free_idx, hit_idx, wr_idx;
  logic hit, live, wr_en, wr_alloc, evt_req, push, pop, fifo_full, fifo_empty, up;
  logic [32:0] diff;
  price_t stored, mag;
  price_evt_t evt_in, head;
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) if (s1_match[i]) hit_idx = IW'(i);
  end
  assign hit = |s1_match;
  assign stored = tbl_price[hit_idx];
  assign diff = {1'b0, s1_price} - {1'b0, stored};
  assign mag = diff[32] ? ~diff[31:0] + 32'd1 : diff[31:0];
  assign up = s1_price > stored;
  assign live = s1_v && !tbl_clear;
  assign wr_alloc = live && !hit && !s1_full;
  assign wr_en = live && (hit || !s1_full);
  assign wr_idx = hit ? hit_idx : s1_free_idx;
  assign evt_req = live && hit && mag >= cfg_threshold && mag != 0;
  // Lookup of the incoming symbol sees the write S2 is about to commit
  always_comb begin
    fwd_match = '0;
    free = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_match[i] = (tbl_valid[i] && tbl_sym[i] == symbol) ||
                     (wr_en && wr_idx == IW'(i) && s1_sym == symbol);
      free[i] = !tbl_valid[i] && !(wr_alloc && s1_free_idx == IW'(i));
    end
    for (int i = DEPTH - 1; i >= 0; i--) if (free[i]) free_idx = IW'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_sym <= '0;
      s1_price <= '0;
      s1_match <= '0;
      s1_free_idx <= '0;
      s1_full <= 1'b0;
      tbl_valid <= '0;
    end else begin
      s1_v <= price_valid;
      if (price_valid) begin
        s1_sym <= symbol;
        s1_price <= price;
        s1_match <= tbl_clear ? '0 : fwd_match;
        s1_free_idx <= tbl_clear ? '0 : free_idx;
        s1_full <= !tbl_clear && ~|free;
      end
      if (tbl_clear) tbl_valid <= '0;
      else if (wr_alloc) tbl_valid[wr_idx] <= 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en) begin
      tbl_sym[wr_idx] <= s1_sym;
      tbl_price[wr_idx] <= s1_price;
    end
  assign tbl_full = &tbl_valid;
  assign pop = evt_valid && evt_ready;
  assign push = evt_req && (!fifo_full || pop);
  assign evt_in = '{symbol: s1_sym, prev_price: stored, price: s1_price, up: up};
  price_evt_fifo #(.DEPTH(EVT_FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(evt_in),
    .dout(head), .full(fifo_full), .empty(fifo_empty)
  );
  assign evt_valid = !fifo_empty;
  assign evt_symbol = head.symbol;
  assign evt_prev_price = head.prev_price;
  assign evt_price = head.price;
  assign evt_up = head.up;
`ifdef PRICE_MOVE_STATS_EN
  logic [CNT_W-1:0] miss_cnt, evt_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      miss_cnt <= '0;
      evt_cnt <= '0;
    end else begin
      if (live && !hit && s1_full && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      if (evt_req && !push && evt_cnt != '1) evt_cnt <= evt_cnt + 1'b1;
    end
  assign miss_drop_count = miss_cnt;
  assign evt_drop_count = evt_cnt;
`else
  assign miss_drop_count = '0;
  assign evt_drop_count = '0;
`endif
endmodule

// File: tb/tb_price_move_detector.sv
// tb_price_move_detector: directed checks of the price move detector
module tb_price_move_detector;
  import price_move_pkg::*;
`ifdef PRICE_MOVE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk = 0, rst_n = 0, price_valid = 0, tbl_clear = 0, evt_ready = 0;
  symbol_t symbol = '0;
  price_t price = '0, cfg_threshold = 32'd1000;
  logic evt_valid, evt_up, tbl_full;
  symbol_t evt_symbol;
  price_t evt_prev_price, evt_price;
  logic [CNT_W-1:0] miss_drop_count, evt_drop_count;
  int checks = 0, fails = 0;
  price_move_detector #(.DEPTH(4), .EVT_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .symbol(symbol), .price(price), .price_valid(price_valid),
    .cfg_threshold(cfg_threshold), .tbl_clear(tbl_clear), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_symbol(evt_symbol), .evt_prev_price(evt_prev_price),
    .evt_price(evt_price), .evt_up(evt_up), .tbl_full(tbl_full),
    .miss_drop_count(miss_drop_count), .evt_drop_count(evt_drop_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input symbol_t s, input price_t p);
    symbol = s;
    price = p;
    price_valid = 1;
    tick();
    price_valid = 0;
  endtask
  task automatic head(input string tag, input symbol_t s, input price_t pp, input price_t p, input logic u);
    check({tag, ".valid"}, 64'(evt_valid), 1);
    check({tag, ".sym"}, 64'(evt_symbol), 64'(s));
    check({tag, ".prev"}, 64'(evt_prev_price), 64'(pp));
    check({tag, ".price"}, 64'(evt_price), 64'(p));
    check({tag, ".up"}, 64'(evt_up), 64'(u));
  endtask
  task automatic pop_ev(input string tag, input symbol_t s, input price_t pp, input price_t p, input logic u);
    head(tag, s, pp, p, u);
    evt_ready = 1;
    tick();
    evt_ready = 0;
  endtask
  initial begin
    tick();
    tick();
    check("rst.valid", 64'(evt_valid), 0);
    check("rst.sym", 64'(evt_symbol), 0);
    check("rst.full", 64'(tbl_full), 0);
    check("rst.miss", 64'(miss_drop_count), 0);
    rst_n = 1;
    tick();
    send("AAPL", 100000);
    tick();
    tick();
    check("first.noevt", 64'(evt_valid), 0);
    send("AAPL", 101500);
    check("lat.n1", 64'(evt_valid), 0);
    tick();
    pop_ev("up", "AAPL", 100000, 101500, 1);
    check("up.drained", 64'(evt_valid), 0);
    send("AAPL", 101000);
    tick();
    tick();
    check("below.noevt", 64'(evt_valid), 0);
    send("AAPL", 99900);
    tick();
    pop_ev("down", "AAPL", 101000, 99900, 0);
    send("AAPL", 100900);
    tick();
    pop_ev("exact", "AAPL", 99900, 100900, 1);
    send("MSFT", 50000);
    send("MSFT", 52000);
    send("MSFT", 50500);
    tick();
    tick();
    pop_ev("haz1", "MSFT", 50000, 52000, 1);
    pop_ev("haz2", "MSFT", 52000, 50500, 0);
    check("haz.notfull", 64'(tbl_full), 0);
    send("IBM ", 1000);
    send("GOOG", 2000);
    tick();
    tick();
    check("full.set", 64'(tbl_full), 1);
    check("full.miss0", 64'(miss_drop_count), 0);
    send("NVDA", 500);
    tick();
    tick();
    check("full.miss1", 64'(miss_drop_count), 64'(STATS));
    send("NVDA", 5000);
    tick();
    tick();
    check("full.noevt", 64'(evt_valid), 0);
    check("full.miss2", 64'(miss_drop_count), 64'(2 * STATS));
    tbl_clear = 1;
    tick();
    tbl_clear = 0;
    check("clear.full", 64'(tbl_full), 0);
    send("NVDA", 100);
    send("NVDA", 5000);
    tick();
    pop_ev("clear.realloc", "NVDA", 100, 5000, 1);
    for (int i = 1; i <= 6; i++) send("NVDA", price_t'(i * 10000));
    tick();
    tick();
    check("bp.drop", 64'(evt_drop_count), 64'(2 * STATS));
    head("bp.stall0", "NVDA", 5000, 10000, 1);
    tick();
    tick();
    tick();
    head("bp.stall1", "NVDA", 5000, 10000, 1);
    pop_ev("bp.e1", "NVDA", 5000, 10000, 1);
    pop_ev("bp.e2", "NVDA", 10000, 20000, 1);
    pop_ev("bp.e3", "NVDA", 20000, 30000, 1);
    pop_ev("bp.e4", "NVDA", 30000, 40000, 1);
    check("bp.empty", 64'(evt_valid), 0);
    send("NVDA", 90000);
    rst_n = 0;
    #2;
    check("mrst.valid", 64'(evt_valid), 0);
    check("mrst.sym", 64'(evt_symbol), 0);
    check("mrst.full", 64'(tbl_full), 0);
    check("mrst.edrop", 64'(evt_drop_count), 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    tick();
    check("mrst.noevt", 64'(evt_valid), 0);
    check("mrst.miss", 64'(miss_drop_count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
